// File: rtl/edac_scrubber.sv
// Background scrubber for the (39,32) SEC-DED buffer: walks every word, writes back
// single-bit corrections, and counts and flags uncorrectable words for the CPU.
module edac_scrubber #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [15:0]       period,
    input  logic              clr_cnt,
    output logic              req,
    input  logic              gnt,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    input  logic [38:0]       rd_data,
    output logic              wr_en,
    output logic [38:0]       wr_data,
    output logic [15:0]       sbe_cnt,
    output logic [15:0]       dbe_cnt,
    output logic              dbe_flag,
    output logic [ADDR_W-1:0] dbe_addr,
    output logic              pass_done
);

    // Weight-3 check columns shared with the encoder, data bit 0 in the low 7 bits.
    localparam logic [223:0] COLS = {
        7'h62, 7'h61, 7'h58, 7'h54, 7'h52, 7'h51, 7'h4C, 7'h4A,
        7'h49, 7'h46, 7'h45, 7'h34, 7'h32, 7'h31, 7'h2C, 7'h2A,
        7'h29, 7'h26, 7'h25, 7'h23, 7'h1A, 7'h19, 7'h16, 7'h15,
        7'h13, 7'h0E, 7'h0D, 7'h0B, 7'h1C, 7'h43, 7'h38, 7'h07
    };
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_REQ, S_READ, S_CAPT, S_CHECK, S_WRITE, S_NEXT
    } state_t;

    state_t      state;
    logic [15:0] timer;
    logic [38:0] word_p0;
    logic [6:0]  chk_p0;
    logic [6:0]  syn_p0;
    logic [38:0] corr_p0;
    logic        sbe_p0;
    logic        dbe_p0;

    function automatic logic [6:0] calc_check(input logic [31:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) c = c ^ COLS[i*7 +: 7];
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Capture stage: the memory answers one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (state == S_CAPT) word_p0 <= rd_data;
    end

    // Decode stage: single-cycle syndrome classification of the captured word.
    always_comb begin
        chk_p0  = calc_check(word_p0[38:7]);
        syn_p0  = chk_p0 ^ word_p0[6:0];
        corr_p0 = word_p0;
        sbe_p0  = 1'b0;
        dbe_p0  = 1'b0;
        if (syn_p0 != 7'd0) begin
            if ($countones(syn_p0) == 1) begin
                corr_p0[6:0] = chk_p0;
                sbe_p0       = 1'b1;
            end else begin
                for (int i = 0; i < 32; i++) begin
                    if (syn_p0 == COLS[i*7 +: 7]) begin
                        corr_p0[i+7] = ~word_p0[i+7];
                        sbe_p0       = 1'b1;
                    end
                end
                dbe_p0 = ~sbe_p0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            timer     <= 16'd0;
            req       <= 1'b0;
            addr      <= '0;
            rd_en     <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= 39'd0;
            sbe_cnt   <= 16'd0;
            dbe_cnt   <= 16'd0;
            dbe_flag  <= 1'b0;
            dbe_addr  <= '0;
            pass_done <= 1'b0;
        end else begin
            rd_en     <= 1'b0;
            wr_en     <= 1'b0;
            pass_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        if (period == 16'd0) begin
                            state <= S_REQ;
                            req   <= 1'b1;
                        end else begin
                            timer <= period;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (timer <= 16'd1) begin
                        timer <= 16'd0;
                        state <= S_REQ;
                        req   <= 1'b1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_REQ: begin
                    req <= 1'b1;
                    if (gnt) begin
                        state <= S_READ;
                        rd_en <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= gnt ? S_CAPT : S_REQ;
                end
                S_CAPT: begin
                    state <= gnt ? S_CHECK : S_REQ;
                end
                S_CHECK: begin
                    // A revoked grant discards the word; it is re-read and counted later.
                    if (!gnt) begin
                        state <= S_REQ;
                    end else if (sbe_p0) begin
                        sbe_cnt <= sat_inc(sbe_cnt);
                        wr_en   <= 1'b1;
                        wr_data <= corr_p0;
                        state   <= S_WRITE;
                    end else begin
                        if (dbe_p0) begin
                            dbe_cnt  <= sat_inc(dbe_cnt);
                            dbe_flag <= 1'b1;
                            dbe_addr <= addr;
                        end
                        req   <= 1'b0;
                        state <= S_NEXT;
                    end
                end
                S_WRITE: begin
                    req   <= 1'b0;
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (addr == LAST_ADDR) begin
                        addr      <= '0;
                        pass_done <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (period == 16'd0) begin
                        state <= S_REQ;
                        req   <= 1'b1;
                    end else begin
                        timer <= period;
                        state <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req   <= 1'b0;
                end
            endcase
            if (clr_cnt) begin
                sbe_cnt  <= 16'd0;
                dbe_cnt  <= 16'd0;
                dbe_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edac_scrubber.sv
// Bench for edac_scrubber: a 16-word memory model, directed scenarios and randomized
// passes checked against a rule-level SEC-DED reference model.
module tb_edac_scrubber;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 16;
    localparam int LOGN   = 4096;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [15:0]       period = 16'd0;
    logic              clr_cnt = 1'b0;
    logic              gnt = 1'b0;
    logic              req, rd_en, wr_en, dbe_flag, pass_done;
    logic [ADDR_W-1:0] addr, dbe_addr;
    logic [38:0]       rd_data, wr_data;
    logic [15:0]       sbe_cnt, dbe_cnt;

    edac_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
        .clr_cnt(clr_cnt), .req(req), .gnt(gnt), .addr(addr), .rd_en(rd_en),
        .rd_data(rd_data), .wr_en(wr_en), .wr_data(wr_data), .sbe_cnt(sbe_cnt),
        .dbe_cnt(dbe_cnt), .dbe_flag(dbe_flag), .dbe_addr(dbe_addr), .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    // Memory model with one-cycle read latency plus activity logs.
    logic [38:0]       mem [DEPTH];
    logic [38:0]       img [DEPTH];
    logic              load_req = 1'b0;
    int                cyc = 0, rd_n = 0, wr_n = 0, pass_n = 0;
    logic [ADDR_W-1:0] rd_log [LOGN];
    int                rd_t [LOGN];
    logic [ADDR_W-1:0] wr_log_a [LOGN];
    logic [38:0]       wr_log_d [LOGN];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end
        if (rd_en) begin
            rd_data <= mem[addr[3:0]];
            if (rd_n < LOGN) begin
                rd_log[rd_n] <= addr;
                rd_t[rd_n]   <= cyc;
            end
            rd_n <= rd_n + 1;
        end
        if (wr_en) begin
            mem[addr[3:0]] <= wr_data;
            if (wr_n < LOGN) begin
                wr_log_a[wr_n] <= addr;
                wr_log_d[wr_n] <= wr_data;
            end
            wr_n <= wr_n + 1;
        end
        if (pass_done) pass_n <= pass_n + 1;
    end

    // Reference code: four fixed columns, then the remaining weight-3 values in ascending order.
    logic [6:0] cols [32];

    function automatic void build_cols();
        int n;
        cols[0] = 7'h07; cols[1] = 7'h38; cols[2] = 7'h43; cols[3] = 7'h1C;
        n = 4;
        for (int v = 1; v < 128; v++) begin
            logic [6:0] c;
            c = 7'(v);
            if (n < 32 && $countones(c) == 3 && c != 7'h07 && c != 7'h38 &&
                c != 7'h43 && c != 7'h1C) begin
                cols[n] = c;
                n++;
            end
        end
    endfunction

    function automatic logic [6:0] chk_of(input logic [31:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < 32; i++) if (d[i]) c ^= cols[i];
        return c;
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        return {d, chk_of(d)};
    endfunction

    // 0 = clean, 1 = corrected, 2 = uncorrectable; c receives the word memory should hold.
    function automatic int model_fix(input logic [38:0] w, output logic [38:0] c);
        logic [6:0] s;
        c = w;
        s = chk_of(w[38:7]) ^ w[6:0];
        if (s == 7'd0) return 0;
        for (int i = 0; i < 32; i++) begin
            if (cols[i] == s) begin
                c[7+i] = ~w[7+i];
                return 1;
            end
        end
        if ($countones(s) == 1) begin
            c[6:0] = chk_of(w[38:7]);
            return 1;
        end
        return 2;
    endfunction

    int n_assert = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        gnt     = 1'b0;
        clr_cnt = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic load_image();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic fill_clean();
        for (int i = 0; i < DEPTH; i++) img[i] = encode($urandom);
    endtask

    task automatic run_until_pass(input int target, input bit rnd);
        int k;
        k = 0;
        while (pass_n < target && k < 20000) begin
            if (rnd) gnt = ($urandom_range(0, 3) != 0);
            step();
            k++;
        end
        check("pass_reached", 64'(pass_n >= target), 64'd1);
    endtask

    initial begin
        int r0, w0, p0, bad, k, kind, es, ed, ea;
        logic [31:0] d;
        logic [38:0] ex, mask;

        build_cols();

        // Reset state
        reset_n = 1'b0;
        step(); step();
        check("rst_req", 64'(req), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_sbe", 64'(sbe_cnt), 64'd0);
        check("rst_dbe", 64'(dbe_cnt), 64'd0);
        check("rst_flag", 64'(dbe_flag), 64'd0);
        check("rst_dbe_addr", 64'(dbe_addr), 64'd0);
        check("rst_pass", 64'(pass_done), 64'd0);

        // Data-bit, check-bit and double errors in one pass, then counter clear
        do_reset();
        fill_clean();
        img[3] = 39'h86; img[5] = 39'h07; img[9] = 39'h107;
        load_image();
        w0 = wr_n; p0 = pass_n;
        period = 16'd0; gnt = 1'b1; enable = 1'b1;
        run_until_pass(p0 + 1, 1'b0);
        enable = 1'b0;
        repeat (20) step();
        check("tp_wr_count", 64'(wr_n - w0), 64'd2);
        check("tp_wr0_addr", 64'(wr_log_a[w0]), 64'd3);
        check("tp_wr0_data", 64'(wr_log_d[w0]), 64'h87);
        check("tp_wr1_addr", 64'(wr_log_a[w0+1]), 64'd5);
        check("tp_wr1_data", 64'(wr_log_d[w0+1]), 64'h87);
        check("tp_sbe", 64'(sbe_cnt), 64'd2);
        check("tp_dbe", 64'(dbe_cnt), 64'd1);
        check("tp_flag", 64'(dbe_flag), 64'd1);
        check("tp_dbe_addr", 64'(dbe_addr), 64'd9);
        check("tp_mem9_kept", 64'(mem[9]), 64'h107);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("clr_sbe", 64'(sbe_cnt), 64'd0);
        check("clr_dbe", 64'(dbe_cnt), 64'd0);
        check("clr_flag", 64'(dbe_flag), 64'd0);

        // Arbitration: grant withheld, then revoked during capture
        do_reset();
        fill_clean();
        d = $urandom;
        ex = encode(d);
        img[0] = ex ^ (39'd1 << 11);
        load_image();
        r0 = rd_n;
        period = 16'd0; gnt = 1'b0; enable = 1'b1;
        bad = 0;
        repeat (20) begin
            step();
            if (req !== 1'b1 || rd_en !== 1'b0) bad++;
        end
        check("arb_hold", 64'(bad), 64'd0);
        gnt = 1'b1;
        step();
        check("arb_rd_en_lat", 64'(rd_en), 64'd1);
        check("arb_rd_addr", 64'(addr), 64'd0);
        step();
        gnt = 1'b0;
        step();
        check("arb_abandon_addr", 64'(addr), 64'd0);
        check("arb_abandon_req", 64'(req), 64'd1);
        repeat (3) step();
        check("arb_abandon_sbe", 64'(sbe_cnt), 64'd0);
        gnt = 1'b1;
        repeat (4) step();
        check("arb_wr_en", 64'(wr_en), 64'd1);
        check("arb_wr_data", 64'(wr_data), 64'(ex));
        check("arb_sbe_after_check", 64'(sbe_cnt), 64'd1);
        step();
        check("arb_next_req", 64'(req), 64'd0);
        enable = 1'b0;
        repeat (20) step();
        check("arb_counted_once", 64'(sbe_cnt), 64'd1);
        check("arb_reread", 64'(rd_n - r0 >= 2 && rd_log[r0] == 0 && rd_log[r0+1] == 0), 64'd1);
        check("arb_mem0", 64'(mem[0]), 64'(ex));

        // Minimum word period with PERIOD=0 and grant held
        do_reset();
        fill_clean();
        d = $urandom;
        img[2] = encode(d) ^ (39'd1 << 38);
        load_image();
        r0 = rd_n;
        period = 16'd0; gnt = 1'b1; enable = 1'b1;
        k = 0;
        while (rd_n < r0 + 5 && k < 200) begin step(); k++; end
        enable = 1'b0;
        check("per_reads", 64'(rd_n >= r0 + 5), 64'd1);
        check("per_clean0", 64'(rd_t[r0+1] - rd_t[r0]), 64'd5);
        check("per_clean1", 64'(rd_t[r0+2] - rd_t[r0+1]), 64'd5);
        check("per_corr", 64'(rd_t[r0+3] - rd_t[r0+2]), 64'd6);
        check("per_after", 64'(rd_t[r0+4] - rd_t[r0+3]), 64'd5);
        repeat (20) step();

        // Reset asserted during a write-back
        do_reset();
        fill_clean();
        d = $urandom;
        img[0] = encode(d) ^ 39'd4;
        load_image();
        period = 16'd0; gnt = 1'b1; enable = 1'b1;
        k = 0;
        while (wr_en !== 1'b1 && k < 200) begin step(); k++; end
        check("rstw_wr_seen", 64'(wr_en), 64'd1);
        check("rstw_sbe_before", 64'(sbe_cnt), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rstw_wr_en", 64'(wr_en), 64'd0);
        check("rstw_req", 64'(req), 64'd0);
        check("rstw_sbe", 64'(sbe_cnt), 64'd0);
        step(); step();
        check("rstw_no_write", 64'(mem[0]), 64'(img[0]));
        r0 = rd_n;
        reset_n = 1'b1;
        k = 0;
        while (rd_n == r0 && k < 200) begin step(); k++; end
        check("rstw_restart_addr", 64'(rd_log[r0]), 64'd0);
        enable = 1'b0;
        repeat (20) step();

        // Wrap: clean memory, PERIOD=2, two full passes
        do_reset();
        fill_clean();
        load_image();
        r0 = rd_n; w0 = wr_n; p0 = pass_n;
        period = 16'd2; gnt = 1'b1; enable = 1'b1;
        run_until_pass(p0 + 2, 1'b0);
        check("wrap_reads", 64'(rd_n - r0), 64'd32);
        bad = 0;
        for (int i = 0; i < 32; i++) if (rd_log[r0+i] !== ADDR_W'(i % 16)) bad++;
        check("wrap_addr_seq", 64'(bad), 64'd0);
        enable = 1'b0;
        repeat (40) step();
        check("wrap_no_write", 64'(wr_n - w0), 64'd0);
        check("wrap_pass_count", 64'(pass_n - p0), 64'd2);

        // Randomized passes with random grant and error injection
        for (int it = 0; it < 2; it++) begin
            do_reset();
            fill_clean();
            for (int i = 1; i < DEPTH; i++) begin
                kind = $urandom_range(0, 5);
                mask = 39'd0;
                if (kind == 2) mask[7 + $urandom_range(0, 31)] = 1'b1;
                else if (kind == 3) mask[$urandom_range(0, 6)] = 1'b1;
                else if (kind >= 4) begin
                    while ($countones(mask) < kind - 2) mask[$urandom_range(0, 38)] = 1'b1;
                end
                img[i] = img[i] ^ mask;
            end
            load_image();
            p0 = pass_n;
            period = 16'($urandom_range(0, 3));
            enable = 1'b1;
            run_until_pass(p0 + 1, 1'b1);
            enable = 1'b0;
            gnt = 1'b1;
            repeat (40) step();
            es = 0; ed = 0; ea = 0;
            for (int i = 0; i < DEPTH; i++) begin
                kind = model_fix(img[i], ex);
                if (kind == 1) es++;
                if (kind == 2) begin ed++; ea = i; end
                check($sformatf("rnd%0d_mem%0d", it, i), 64'(mem[i]), 64'(ex));
            end
            check("rnd_sbe", 64'(sbe_cnt), 64'(es));
            check("rnd_dbe", 64'(dbe_cnt), 64'(ed));
            check("rnd_flag", 64'(dbe_flag), 64'(ed != 0));
            check("rnd_dbe_addr", 64'(dbe_addr), 64'(ea));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
